// File: rtl/csync_sink.sv
// Clock-domain sink for a 4-phase self-timed pipeline stage: synchronizes the
// request, acknowledges it, and captures the bundled word into a small FIFO.
module csync_sink #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sendin,
  input  logic [DW-1:0]            datain,
  output logic                     ackout,
  input  logic                     en,
  output logic [DW-1:0]            dout,
  output logic                     dvalid,
  input  logic                     dready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACKED = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [0:0]             state, state_n;
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_next;
  logic [AW:0]            remain, count_n;
  logic [DW-1:0]          mem [DEPTH];
  logic                   pop, wr;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sendin};

  assign req_s = sync_q[SYNC_STAGES-1];

  // A pop in the same edge frees the slot, so a full FIFO can still capture.
  assign pop     = dvalid & dready;
  assign wr      = (state == IDLE) & req_s & en & ((count != CNT_FULL) | pop);
  assign rd_next = rd_ptr + AW'(pop);
  assign remain  = count - (AW+1)'(pop);
  assign count_n = remain + (AW+1)'(wr);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (wr)     state_n = ACKED;
      ACKED:   if (!req_s) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= datain;

  // Output register loads from storage as it stood before this edge's write,
  // so a word written into an empty FIFO becomes visible one edge later.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dvalid <= 1'b0;
      dout   <= '0;
    end else begin
      state  <= state_n;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_n;
      dvalid <= (remain != '0);
      if (remain != '0) dout <= mem[rd_next];
    end

  assign ackout = state[0];
endmodule

// File: tb/tb_csync_sink.sv
// Bench for csync_sink: queue-based reference model checked every cycle,
// plus directed handshake scenarios with hand-computed expectations.
module tb_csync_sink;
  localparam int DW = 8, DEPTH = 4, S = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sendin = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          en = 1'b1;
  logic          dready = 1'b0;
  logic          ackout, dvalid;
  logic [DW-1:0] dout;
  logic [2:0]    count;

  int checks = 0, errors = 0;

  csync_sink #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sendin(sendin), .datain(datain),
    .ackout(ackout), .en(en), .dout(dout), .dvalid(dvalid),
    .dready(dready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request seen S edges late, FIFO as a queue,
  // head becomes visible one edge after it is written.
  bit            m_ack = 0, m_dvalid = 0;
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] m_q[$];
  bit            sh[$];

  always @(posedge clk or posedge reset) begin
    bit req, pop, take;
    if (reset) begin
      m_ack = 0; m_dvalid = 0; m_dout = '0;
      m_q.delete(); sh.delete();
      repeat (S) sh.push_back(1'b0);
    end else begin
      req  = sh[0];
      pop  = m_dvalid && dready;
      take = !m_ack && req && en && ((m_q.size() - int'(pop)) < DEPTH);
      if (m_ack && !req) m_ack = 0;
      else if (take)     m_ack = 1;
      if (pop) void'(m_q.pop_front());
      m_dvalid = (m_q.size() != 0);
      if (m_dvalid) m_dout = m_q[0];
      if (take) m_q.push_back(datain);
      void'(sh.pop_front());
      sh.push_back(sendin);
    end
  end

  always @(negedge clk) begin
    chk("m_ackout", ackout, m_ack);
    chk("m_count", count, m_q.size());
    chk("m_dvalid", dvalid, m_dvalid);
    if (m_dvalid) chk("m_dout", dout, m_dout);
  end

  // Pop log and occupancy high-water mark for the wrap-around scenario.
  bit            log_en = 0;
  logic [DW-1:0] popped[$];
  int            max_cnt = 0;
  always @(posedge clk) if (log_en && dvalid && dready) popped.push_back(dout);
  always @(negedge clk) if (int'(count) > max_cnt) max_cnt = int'(count);

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (ackout !== lvl && n < 60) begin tick(); n++; end
    chk(name, (n < 60), 1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    datain = d; sendin = 1'b1;
    wait_ack(1'b1, "ack_rise_timeout");
    sendin = 1'b0;
    wait_ack(1'b0, "ack_fall_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while ((count != 0 || dvalid) && n < 60) begin tick(); n++; end
    chk("drain_timeout", (n < 60), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ackout", ackout, 0); chk("rst_count", count, 0);
    chk("rst_dvalid", dvalid, 0); chk("rst_dout", dout, 0);
    reset = 1'b0;
    tick();

    // Single token latency
    datain = 8'hA5; sendin = 1'b1;
    tick(); tick();
    chk("tok_ack_e2", ackout, 0);
    tick();
    chk("tok_ack_e3", ackout, 1); chk("tok_cnt_e3", count, 1); chk("tok_dv_e3", dvalid, 0);
    tick();
    chk("tok_dv_e4", dvalid, 1); chk("tok_dout_e4", dout, 8'hA5);
    sendin = 1'b0;
    tick(); tick();
    chk("tok_ackfall_e2", ackout, 1);
    tick();
    chk("tok_ackfall_e3", ackout, 0);
    dready = 1'b1; tick(); dready = 1'b0;
    chk("tok_read_cnt", count, 0); chk("tok_read_dv", dvalid, 0);

    // Fill and stall, then concurrent read/write at full
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("fill_cnt", count, 4);
    datain = 8'h05; sendin = 1'b1;
    repeat (6) tick();
    chk("stall_ack", ackout, 0); chk("stall_cnt", count, 4); chk("stall_dout", dout, 8'h01);
    dready = 1'b1; tick(); dready = 1'b0;
    chk("full_rw_ack", ackout, 1); chk("full_rw_cnt", count, 4); chk("full_rw_dout", dout, 8'h02);
    sendin = 1'b0;
    wait_ack(1'b0, "stall_fall_timeout");
    dready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_dv", dvalid, 1);
      chk("order_dout", dout, 8'(2 + i));
      tick();
    end
    chk("order_empty_cnt", count, 0); chk("order_empty_dv", dvalid, 0);

    // Wrap-around with the consumer always ready
    popped.delete(); log_en = 1; max_cnt = 0;
    for (int i = 0; i < 10; i++) send(8'(8'h10 + i));
    drain();
    log_en = 0;
    chk("wrap_n", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++) chk("wrap_word", popped[i], 8'(8'h10 + i));
    chk("wrap_max_le_depth", (max_cnt <= DEPTH), 1);

    // Enable gating
    en = 1'b0; datain = 8'h77; sendin = 1'b1;
    repeat (20) tick();
    chk("en_ack", ackout, 0); chk("en_cnt", count, 0);
    en = 1'b1; tick();
    chk("en_ack_on", ackout, 1); chk("en_cnt_on", count, 1);
    sendin = 1'b0;
    wait_ack(1'b0, "en_fall_timeout");
    drain();

    // Reset in the middle of a handshake
    dready = 1'b0;
    send(8'h31);
    datain = 8'h32; sendin = 1'b1;
    wait_ack(1'b1, "mid_rise_timeout");
    chk("mid_pre_ack", ackout, 1); chk("mid_pre_cnt", count, 2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ack", ackout, 0); chk("mid_rst_cnt", count, 0); chk("mid_rst_dv", dvalid, 0);
    tick(); reset = 1'b0;
    tick(); tick();
    chk("rel_ack_e2", ackout, 0);
    tick();
    chk("rel_ack_e3", ackout, 1); chk("rel_cnt_e3", count, 1);
    tick();
    chk("rel_dv", dvalid, 1); chk("rel_dout", dout, 8'h32);
    sendin = 1'b0;
    wait_ack(1'b0, "rel_fall_timeout");
    chk("rel_cnt_end", count, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
